// File: rtl/kgd_blitter.sv
// kgd_blitter: Wishbone-programmed rectangle fill engine that drives the KGD register port as a bus master.
// Build option KGD_BLT_XOR_EN adds a per-byte read-modify-write (PAT ^ existing byte) selected by CSR.b1.
module kgd_blitter #(
   parameter int         STRIDE  = 50,
   parameter int         GAP     = 2,
   parameter logic [2:0] KGD_ADR = 3'b000
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [2:0]  wb_adr_i,
   input  logic [15:0] wb_dat_i,
   output logic [15:0] wb_dat_o,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [1:0]  wb_sel_i,
   output logic        wb_ack_o,
   output logic [2:0]  m_adr_o,
   output logic [15:0] m_dat_o,
   input  logic [15:0] m_dat_i,
   output logic        m_cyc_o,
   output logic        m_stb_o,
   output logic        m_we_o,
   output logic [1:0]  m_sel_o,
   input  logic        m_ack_i,
   output logic        irq_o
);
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

`ifdef KGD_BLT_XOR_EN
   typedef enum logic [2:0] {IDLE, WADR, G1, RD, G3, WDAT, G2, NEXT} state_t;
`else
   typedef enum logic [2:0] {IDLE, WADR, G1, WDAT, G2, NEXT} state_t;
`endif

   state_t        state, nstate;
   logic [GW-1:0] gcnt;
   logic [13:0]   dst, cur, line;
   logic [7:0]    w, h, pat, col, row, wr_byte;
   logic          ie, done, abort_pend, xor_bit;
   logic          busy, acc, wr, csr_wr, cfg_wr, go_req, abort_req, zero, gap_st, gap_end, last;
   logic [15:0]   rd_mux;
   logic          unused_in;

   assign busy      = (state != IDLE);
   assign acc       = wb_cyc_i & wb_stb_i & ~wb_ack_o;
   assign wr        = acc & wb_we_i;
   assign csr_wr    = wr && (wb_adr_i[2:1] == 2'd0);
   assign cfg_wr    = wr & ~busy;
   // ABORT in the same write suppresses GO; ABORT only means something while busy
   assign go_req    = csr_wr & wb_sel_i[0] & wb_dat_i[0] & ~(wb_sel_i[1] & wb_dat_i[14]) & ~busy;
   assign abort_req = csr_wr & wb_sel_i[1] & wb_dat_i[14] & busy;
   assign zero      = (w == 8'd0) || (h == 8'd0);
   assign gap_end   = (gcnt == GW'(GAP - 1));
   assign last      = (col == w - 8'd1) && (row == h - 8'd1);
   assign irq_o     = done & ie;
   assign unused_in = ^{m_dat_i, wb_adr_i[0]};

`ifdef KGD_BLT_XOR_EN
   logic       xor_mode;
   logic [7:0] rd_byte;
   assign xor_bit = xor_mode;
   assign wr_byte = xor_mode ? (pat ^ rd_byte) : pat;
   assign gap_st  = (state == G1) || (state == G3) || (state == G2);

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         xor_mode <= 1'b0;
         rd_byte  <= 8'h00;
      end else begin
         if (csr_wr && wb_sel_i[0]) xor_mode <= wb_dat_i[1];
         if (state == RD && m_ack_i) rd_byte <= m_dat_i[7:0];
      end
   end
`else
   assign xor_bit = 1'b0;
   assign wr_byte = pat;
   assign gap_st  = (state == G1) || (state == G2);
`endif

   always_comb begin
      rd_mux = 16'h0000;
      case (wb_adr_i[2:1])
         2'd0: rd_mux = {busy, 7'b0, done, ie, 4'b0, xor_bit, 1'b0};
         2'd1: rd_mux = {2'b00, dst};
         2'd2: rd_mux = {h, w};
         default: rd_mux = {8'h00, pat};
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state      <= IDLE;
         wb_ack_o   <= 1'b0;
         wb_dat_o   <= 16'h0000;
         dst        <= '0;
         cur        <= '0;
         line       <= '0;
         w          <= '0;
         h          <= '0;
         pat        <= '0;
         col        <= '0;
         row        <= '0;
         ie         <= 1'b0;
         done       <= 1'b0;
         abort_pend <= 1'b0;
         gcnt       <= '0;
      end else begin
         state    <= nstate;
         wb_ack_o <= wb_cyc_i & wb_stb_i & ~wb_ack_o;
         if (acc) wb_dat_o <= rd_mux;
         if (cfg_wr && wb_adr_i[2:1] == 2'd1) begin
            if (wb_sel_i[0]) dst[7:0]  <= wb_dat_i[7:0];
            if (wb_sel_i[1]) dst[13:8] <= wb_dat_i[13:8];
         end
         if (cfg_wr && wb_adr_i[2:1] == 2'd2) begin
            if (wb_sel_i[0]) w <= wb_dat_i[7:0];
            if (wb_sel_i[1]) h <= wb_dat_i[15:8];
         end
         if (cfg_wr && wb_adr_i[2:1] == 2'd3 && wb_sel_i[0]) pat <= wb_dat_i[7:0];
         if (csr_wr && wb_sel_i[0]) begin
            ie <= wb_dat_i[6];
            if (wb_dat_i[7]) done <= 1'b0;
         end
         if (abort_req) abort_pend <= 1'b1;
         if (go_req) begin
            done       <= zero;
            cur        <= dst;
            line       <= dst;
            col        <= '0;
            row        <= '0;
            abort_pend <= 1'b0;
         end
         gcnt <= (gap_st && !gap_end) ? gcnt + 1'b1 : '0;
         if (state == NEXT) begin
            if (col == w - 8'd1) begin
               col  <= '0;
               row  <= row + 8'd1;
               line <= line + 14'(STRIDE);
               cur  <= line + 14'(STRIDE);
            end else begin
               col <= col + 8'd1;
               cur <= cur + 14'd1;
            end
            if (nstate == IDLE) begin
               done       <= 1'b1;
               abort_pend <= 1'b0;
            end
         end
      end
   end

   // abort is honoured at the byte boundary so KGD never holds an address without its data
   always_comb begin
      nstate  = state;
      m_cyc_o = 1'b0;
      m_stb_o = 1'b0;
      m_we_o  = 1'b0;
      m_adr_o = 3'b000;
      m_dat_o = 16'h0000;
      m_sel_o = 2'b00;
      case (state)
         IDLE: if (go_req && !zero) nstate = WADR;
         WADR: begin
            m_cyc_o = 1'b1;
            m_stb_o = 1'b1;
            m_we_o  = 1'b1;
            m_adr_o = KGD_ADR | 3'b100;
            m_dat_o = {2'b00, cur};
            m_sel_o = 2'b11;
            if (m_ack_i) nstate = G1;
         end
`ifdef KGD_BLT_XOR_EN
         G1: if (gap_end) nstate = xor_mode ? RD : WDAT;
         RD: begin
            m_cyc_o = 1'b1;
            m_stb_o = 1'b1;
            m_adr_o = KGD_ADR | 3'b010;
            m_sel_o = 2'b01;
            if (m_ack_i) nstate = G3;
         end
         G3: if (gap_end) nstate = WDAT;
`else
         G1: if (gap_end) nstate = WDAT;
`endif
         WDAT: begin
            m_cyc_o = 1'b1;
            m_stb_o = 1'b1;
            m_we_o  = 1'b1;
            m_adr_o = KGD_ADR | 3'b010;
            m_dat_o = {8'h00, wr_byte};
            m_sel_o = 2'b01;
            if (m_ack_i) nstate = G2;
         end
         G2: if (gap_end) nstate = NEXT;
         NEXT: nstate = (abort_pend || last) ? IDLE : WADR;
         default: nstate = IDLE;
      endcase
   end
endmodule

// File: tb/tb_kgd_blitter.sv
// Self-checking bench for kgd_blitter: KGD slave model with byte memory, fill reference model, directed and random fills.
module tb_kgd_blitter;
   localparam int STRIDE = 50;
   localparam int GAP    = 2;

   logic        clk = 1'b0, rst = 1'b1;
   logic [2:0]  adr = '0;
   logic [15:0] dat_w = '0, dat_r;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, ack;
   logic [1:0]  sel = '0;
   logic [2:0]  m_adr;
   logic [15:0] m_dat_o, m_dat_i;
   logic        m_cyc, m_stb, m_we, m_ack, irq;
   logic [1:0]  m_sel;

   always #5 clk = ~clk;

   kgd_blitter dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(dat_r),
      .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel), .wb_ack_o(ack),
      .m_adr_o(m_adr), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_cyc_o(m_cyc), .m_stb_o(m_stb),
      .m_we_o(m_we), .m_sel_o(m_sel), .m_ack_i(m_ack), .irq_o(irq)
   );

   typedef struct packed {logic [2:0] a; logic [15:0] d;} xact_t;
   typedef struct {int dst; int w; int h; logic [7:0] pat; bit ie; bit spur; int cycles;} vec_t;

   // KGD slave: ack in the 3rd cycle of strobe, optional spurious ack two cycles later
   logic [7:0]  mem [16384];
   logic [13:0] kaddr = '0;
   logic [1:0]  scnt, spur;
   bit          spur_en = 1'b0;
   xact_t       log_q[$], exp_q[$];
   int          rises = 0, idle = 100, gap_bad = 0;
   logic        stb_d;
   int          errs = 0, checks = 0;

   assign m_dat_i = {8'h00, mem[kaddr]};

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ack <= 1'b0; scnt <= '0; spur <= '0;
      end else begin
         if (m_cyc && m_stb && m_ack && m_we) begin
            log_q.push_back({m_adr, m_dat_o});
            if (m_adr == 3'b100) kaddr <= m_dat_o[13:0];
            else if (m_adr == 3'b010) mem[kaddr] <= m_dat_o[7:0];
         end
         if (m_ack) begin
            m_ack <= 1'b0; scnt <= '0;
            spur <= (spur_en && spur == 2'd0) ? 2'd1 : 2'd0;
         end else if (spur == 2'd1) begin
            m_ack <= 1'b1; spur <= 2'd2;
         end else if (m_cyc && m_stb) begin
            scnt <= scnt + 2'd1;
            if (scnt == 2'd1) m_ack <= 1'b1;
         end else scnt <= '0;
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         stb_d <= 1'b0; idle <= 100;
      end else begin
         if (m_stb && !stb_d) begin
            rises <= rises + 1;
            if (idle < GAP) gap_bad <= gap_bad + 1;
         end
         idle  <= m_stb ? 0 : idle + 1;
         stb_d <= m_stb;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wbw(input logic [2:0] a, input logic [15:0] d, input logic [1:0] s);
      int n = 0;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_w = d; sel = s;
      do begin @(posedge clk); #1; n++; end while (!ack && n < 10);
      if (!ack) chk("wb_write_ack_timeout", 0, 1);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic wbr(input logic [2:0] a, output logic [15:0] d);
      int n = 0;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 2'b11;
      do begin @(posedge clk); #1; n++; end while (!ack && n < 10);
      if (!ack) chk("wb_read_ack_timeout", 0, 1);
      d = dat_r;
      cyc = 1'b0; stb = 1'b0;
   endtask

   task automatic wait_irq(input int lim, output int n);
      n = 0;
      while (!irq && n < lim) begin @(posedge clk); #1; n++; end
      if (!irq) chk("irq_timeout", 0, 1);
   endtask

   // Reference: every byte of the rectangle, row-major, one address write then one data write
   task automatic build_exp(input int d, input int w, input int h, input logic [7:0] p);
      exp_q.delete();
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++) begin
            exp_q.push_back({3'b100, 16'((d + r * STRIDE + c) % 16384)});
            exp_q.push_back({3'b010, {8'h00, p}});
         end
   endtask

   task automatic cmp_log(input string name, input int len);
      int bad = -1;
      for (int i = 0; i < len && i < log_q.size() && i < exp_q.size(); i++)
         if (log_q[i] !== exp_q[i] && bad < 0) bad = i;
      chk({name, "_count"}, log_q.size(), len);
      chk({name, "_first_bad_index"}, bad, -1);
   endtask

   task automatic run_fill(input string name, input vec_t v);
      int n;
      logic [15:0] r;
      log_q.delete(); spur_en = v.spur;
      wbw(3'd2, 16'(v.dst), 2'b11);
      wbw(3'd4, {8'(v.h), 8'(v.w)}, 2'b11);
      wbw(3'd6, {8'h00, v.pat}, 2'b11);
      build_exp(v.dst, v.w, v.h, v.pat);
      wbw(3'd0, v.ie ? 16'h0041 : 16'h0001, 2'b11);
      if (v.ie) begin
         wait_irq(5000, n);
         chk({name, "_cycles"}, n, v.cycles);
      end else begin
         n = 0;
         do begin wbr(3'd0, r); n++; end while (!r[7] && n < 2000);
      end
      chk({name, "_irq"}, irq, v.ie);
      wbr(3'd0, r);
      chk({name, "_csr"}, r, v.ie ? 16'h00C0 : 16'h0080);
      cmp_log(name, exp_q.size());
      wbw(3'd0, 16'h0080, 2'b01);
   endtask

   vec_t tbl[6];

   initial begin
      logic [15:0] r;
      int n, r0;
      vec_t v;
      for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
      tbl[0] = '{dst: 0,     w: 1, h: 1, pat: 8'hA5, ie: 1, spur: 0, cycles: 11};
      tbl[1] = '{dst: 16380, w: 8, h: 2, pat: 8'h00, ie: 1, spur: 0, cycles: 176};
      tbl[2] = '{dst: 100,   w: 0, h: 3, pat: 8'h55, ie: 1, spur: 0, cycles: 0};
      tbl[3] = '{dst: 200,   w: 3, h: 0, pat: 8'h55, ie: 1, spur: 0, cycles: 0};
      tbl[4] = '{dst: 16383, w: 2, h: 2, pat: 8'h3C, ie: 1, spur: 1, cycles: 44};
      tbl[5] = '{dst: 10,    w: 3, h: 1, pat: 8'h7E, ie: 0, spur: 0, cycles: 33};

      // reset state
      #1;
      chk("in_reset_mbus", {m_adr, m_dat_o, m_cyc, m_stb, m_we, m_sel}, 0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      chk("post_reset_slave", {ack, dat_r, irq}, 0);
      wbr(3'd0, r); chk("reset_csr", r, 16'h0000);
      wbr(3'd2, r); chk("reset_dst", r, 16'h0000);
      wbr(3'd4, r); chk("reset_size", r, 16'h0000);
      wbr(3'd6, r); chk("reset_pat", r, 16'h0000);

      // byte lanes
      wbw(3'd4, 16'hFF03, 2'b01); wbr(3'd4, r); chk("sel_low_only", r, 16'h0003);
      wbw(3'd4, 16'h1277, 2'b10); wbr(3'd4, r); chk("sel_high_only", r, 16'h1203);

`ifdef KGD_BLT_XOR_EN
      mem[777] = 8'h0F; log_q.delete(); spur_en = 0;
      wbw(3'd2, 16'd777, 2'b11); wbw(3'd4, 16'h0101, 2'b11); wbw(3'd6, 16'h00FF, 2'b11);
      wbw(3'd0, 16'h0043, 2'b11);
      wait_irq(200, n);
      chk("xor_write_count", log_q.size(), 2);
      chk("xor_written", log_q[1], {3'b010, 16'h00F0});
      chk("xor_mem", mem[777], 8'hF0);
      wbw(3'd0, 16'h0080, 2'b01);
`else
      wbw(3'd0, 16'h0002, 2'b01); wbr(3'd0, r); chk("xor_bit_reads_0", r, 16'h0000);
`endif

      for (int i = 0; i < 6; i++) run_fill($sformatf("tbl%0d", i), tbl[i]);
      chk("row1_start_addr", log_q.size() > 0 ? 0 : 1, 0);
      for (int i = 0; i < 6; i++) begin
         v.dst = $urandom_range(0, 16383); v.w = $urandom_range(1, 5); v.h = $urandom_range(1, 3);
         v.pat = 8'($urandom); v.ie = 1; v.spur = $urandom_range(0, 1); v.cycles = 11 * v.w * v.h;
         run_fill($sformatf("rnd%0d", i), v);
      end

      // wrap row start: 16380 + 50 wraps to 46
      log_q.delete(); spur_en = 0;
      wbw(3'd2, 16'd16380, 2'b11); wbw(3'd4, 16'h0201, 2'b11); wbw(3'd6, 16'h0000, 2'b11);
      wbw(3'd0, 16'h0041, 2'b11);
      wait_irq(500, n);
      chk("wrap_row1_addr", log_q[2], {3'b100, 16'd46});
      wbw(3'd0, 16'h0080, 2'b01);

      // config writes while busy are ignored
      log_q.delete();
      wbw(3'd2, 16'd500, 2'b11); wbw(3'd4, 16'h0104, 2'b11); wbw(3'd6, 16'h0011, 2'b11);
      wbw(3'd0, 16'h0041, 2'b11);
      wbw(3'd6, 16'h0033, 2'b11); wbw(3'd2, 16'h0000, 2'b11); wbw(3'd4, 16'h0000, 2'b11);
      wbr(3'd0, r); chk("busy_bit", r[15], 1'b1);
      wait_irq(1000, n);
      build_exp(500, 4, 1, 8'h11); cmp_log("busy_ignore", 8);
      wbr(3'd6, r); chk("busy_pat_kept", r, 16'h0011);
      wbr(3'd2, r); chk("busy_dst_kept", r, 16'd500);
      wbw(3'd0, 16'h0080, 2'b01);

      // GO together with ABORT while idle: nothing starts
      r0 = rises;
      wbw(3'd0, 16'h4001, 2'b11);
      repeat (20) @(posedge clk); #1;
      chk("go_abort_no_stb", rises - r0, 0);
      wbr(3'd0, r); chk("go_abort_csr", r, 16'h0000);

      // ABORT during byte 5 of 10x1: byte 5 finishes, nothing more
      log_q.delete(); r0 = rises;
      wbw(3'd2, 16'd1000, 2'b11); wbw(3'd4, 16'h010A, 2'b11); wbw(3'd6, 16'h005A, 2'b11);
      build_exp(1000, 10, 1, 8'h5A);
      wbw(3'd0, 16'h0041, 2'b11);
      n = 0;
      while (log_q.size() < 9 && n < 500) begin @(posedge clk); #1; n++; end
      wbw(3'd0, 16'h4040, 2'b11);
      wait_irq(200, n);
      repeat (30) @(posedge clk); #1;
      cmp_log("abort", 10);
      chk("abort_stb_count", rises - r0, 10);
      wbr(3'd0, r); chk("abort_csr", r, 16'h00C0);
      wbw(3'd0, 16'h0080, 2'b01);

      // async reset in the middle of a master cycle
      wbw(3'd2, 16'd3000, 2'b11); wbw(3'd4, 16'h010A, 2'b11);
      wbw(3'd0, 16'h0041, 2'b11);
      repeat (25) @(posedge clk);
      n = 0;
      while (!m_stb && n < 20) begin @(posedge clk); #1; n++; end
      chk("pre_reset_stb", m_stb, 1'b1);
      rst = 1'b1; #1;
      chk("reset_mid_mbus", {m_adr, m_dat_o, m_cyc, m_stb, m_we, m_sel}, 0);
      chk("reset_mid_slave", {ack, dat_r, irq}, 0);
      @(negedge clk) rst = 1'b0;
      wbr(3'd0, r); chk("reset_mid_csr", r, 16'h0000);

      chk("gap_violations", gap_bad, 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
